// File: rtl/dl_reg_rst.sv
// Parameterized D register with asynchronous active-low reset to RST_VAL.
// Define DL_REG_RST_ASSERT_EN to compile in the built-in self-check assertions.
module dl_reg_rst #(
   parameter int                  NUM_BITS = 1,
   parameter logic [NUM_BITS-1:0] RST_VAL  = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_BITS-1:0] d,
   output logic [NUM_BITS-1:0] q
);

   logic [NUM_BITS-1:0] q_d;
   logic [NUM_BITS-1:0] q_q;

   assign q_d = d;

   // NOTE: non-blocking assignment keeps every register that samples q this edge seeing the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

`ifdef DL_REG_RST_ASSERT_EN
   if (NUM_BITS < 1) begin : g_width_check
      $error("%m: NUM_BITS must be at least 1, got %0d", NUM_BITS);
   end

   // Set by the first edge after reset release; cleared by any reset pulse, even between edges.
   logic                armed_q;
   logic [NUM_BITS-1:0] d_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q  <= 1'b0;
         d_prev_q <= RST_VAL;
      end else begin
         armed_q  <= 1'b1;
         d_prev_q <= d;
      end
   end

   a_reset_value: assert property (@(posedge clk) !rst_n |-> (q_q == RST_VAL))
      else $error("%m: q=%h while in reset, expected RST_VAL=%h", q_q, RST_VAL);

   a_capture: assert property (@(posedge clk) disable iff (!rst_n)
                               armed_q |-> (q_q == $past(d)))
      else $error("%m: q=%h, expected d from previous edge=%h", q_q, d_prev_q);

   a_known: assert property (@(posedge clk) disable iff (!rst_n)
                             armed_q |-> !$isunknown(q_q))
      else $error("%m: q=%h has X/Z bits after reset release, expected all known", q_q);
`endif

endmodule

// File: tb/tb_dl_reg_rst.sv
// Scoreboard bench for dl_reg_rst: stimulus and edge model push expectations, a monitor pops and compares.
module tb_dl_reg_rst;
   localparam int          W       = 32;
   localparam logic [W-1:0] RST_VAL = 32'hc0ffee69;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] d     = '0;
   logic [W-1:0] q;

   int errors   = 0;
   int n_checks = 0;

   logic [W-1:0] exp_q[$];
   string        name_q[$];

   bit           model_en = 1'b1;
   string        phase    = "rst_hold";
   logic [W-1:0] edge_exp;

   dl_reg_rst #(
      .NUM_BITS(W),
      .RST_VAL (RST_VAL)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (d),
      .q    (q)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic expect_now(input string nm, input logic [W-1:0] e);
      name_q.push_back(nm);
      exp_q.push_back(e);
   endtask

   // Monitor: compares q against each expectation at the moment it is posted.
   initial begin : monitor
      forever begin
         wait (exp_q.size() != 0);
         check(name_q.pop_front(), q, exp_q.pop_front());
      end
   end

   // Reference rule: after every rising edge q holds d seen at that edge, or RST_VAL if in reset.
   always @(posedge clk) begin
      if (model_en) begin
         edge_exp = rst_n ? d : RST_VAL;
         #1 expect_now(phase, edge_exp);
      end
   end

   initial begin : stimulus
      longint t_end;
      int     dly;

      // Async reset with no clock edge nearby (first edge is at t=5).
      #2 rst_n = 1'b0;
      #1 expect_now("rst_async", RST_VAL);
      d = 32'h12345678;

      // Held in reset across two edges, then released mid-cycle.
      #19;
      d     = 32'hdeadbeef;
      rst_n = 1'b1;
      phase = "release";
      #1 expect_now("release_hold", RST_VAL);
      @(posedge clk);
      #2;

      // Random d, changing 0..10 units apart but never on a rising edge.
      phase = "random";
      t_end = $time + 500;
      while ($time < t_end) begin
         dly = $urandom_range(10, 0);
         if ((($time + dly) % 10) == 5) dly++;
         #dly;
         d = $urandom;
      end

      // Reset pulse between edges while q = 0000ffff.
      @(negedge clk);
      d     = 32'h0000ffff;
      phase = "load_ffff";
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 expect_now("mid_rst", RST_VAL);
      #1;
      rst_n = 1'b1;
      d     = 32'ha5a5a5a5;
      phase = "mid_release";
      #1 expect_now("mid_release_hold", RST_VAL);

      // Reset falling in the same timestep as a clock edge.
      @(negedge clk);
      model_en = 1'b0;
      d        = 32'hffffffff;
      @(posedge clk);
      rst_n = 1'b0;
      #1 expect_now("coincident", RST_VAL);
      repeat (2) @(posedge clk);
      #1 expect_now("coincident_hold", RST_VAL);

      @(negedge clk);
      rst_n    = 1'b1;
      d        = 32'h0badf00d;
      phase    = "final";
      model_en = 1'b1;
      repeat (2) begin
         @(negedge clk);
         d = $urandom;
      end
      @(posedge clk);
      #3;

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) #1;
      check("scoreboard_drain", W'(exp_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, n_checks);
      $finish;
   end
endmodule
